// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream instruction/format/tag, downstream immediate/tag.
// imm_err exists only when IMM_EXT_ILLEGAL_CHK_EN is defined.
interface imm_extend_pipe_if #(
    parameter int DPW   = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [DPW-8:0]   instr_ext;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DPW-1:0]   immextD;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
    logic             imm_err;

    modport master (
        output in_valid, instr_ext, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immextD, out_tag, imm_err
    );
    modport slave (
        input  in_valid, instr_ext, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immextD, out_tag, imm_err
    );
`else
    modport master (
        output in_valid, instr_ext, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immextD, out_tag
    );
    modport slave (
        input  in_valid, instr_ext, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immextD, out_tag
    );
`endif
endinterface

// File: rtl/imm_extend_pipe.sv
// RV32 immediate extender (I/S/B/U/J) with a two-entry skid buffer; optional IMM_EXT_ILLEGAL_CHK_EN adds imm_err.
// Latency: 1 cycle from input transfer to out_valid when empty.
// Backpressure: in_ready is registered (state != FULL); skid absorbs the entry in flight when out_ready drops.
module imm_extend_pipe #(
    parameter int DPW   = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             flush,
    imm_extend_pipe_if.slave pipe
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [DPW-1:0]   out_imm_q, skid_imm_q, imm_new;
    logic [TAG_W-1:0] out_tag_q, skid_tag_q;
    logic [31:0]      imm32;
    logic [31:7]      instr_w;
    logic             sgn;
    logic             in_xfer, out_xfer, out_valid;
    logic             load_out_new, load_out_skid, load_skid;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
    logic             out_err_q, skid_err_q, err_new;
    assign err_new = (pipe.immsrc > 3'd4);
`endif

    // Only instruction bits 31:7 carry immediate fields; bit 31 is the sign for every format.
    assign instr_w = pipe.instr_ext[24:0];
    assign sgn     = instr_w[31];

    always_comb begin
        imm32 = '0;
        case (pipe.immsrc)
            3'b000:  imm32 = {{20{sgn}}, instr_w[31:20]};
            3'b001:  imm32 = {{20{sgn}}, instr_w[31:25], instr_w[11:7]};
            3'b010:  imm32 = {{19{sgn}}, instr_w[31], instr_w[7], instr_w[30:25],
                              instr_w[11:8], 1'b0};
            3'b011:  imm32 = {instr_w[31:12], 12'b0};
            3'b100:  imm32 = {{11{sgn}}, instr_w[31], instr_w[19:12], instr_w[20],
                              instr_w[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_new = DPW'(signed'(imm32));
    end

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = pipe.in_valid & in_ready_q;
    assign out_xfer  = out_valid & pipe.out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_out_new = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_out_new = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        load_out_skid = 1'b1;
                        state_d       = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
            out_err_q  <= 1'b0;
            skid_err_q <= 1'b0;
`endif
        end else begin
            if (load_out_new) begin
                out_imm_q <= imm_new;
                out_tag_q <= pipe.in_tag;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                out_err_q <= err_new;
`endif
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_tag_q <= skid_tag_q;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                out_err_q <= skid_err_q;
`endif
            end
            if (load_skid) begin
                skid_imm_q <= imm_new;
                skid_tag_q <= pipe.in_tag;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                skid_err_q <= err_new;
`endif
            end
        end
    end

    assign pipe.in_ready  = in_ready_q;
    assign pipe.out_valid = out_valid;
    assign pipe.immextD   = out_imm_q;
    assign pipe.out_tag   = out_tag_q;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
    assign pipe.imm_err   = out_err_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: queue-based reference model checked every cycle, plus directed scenarios.
module tb_imm_extend_pipe;
    localparam int DPW   = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    logic clk;
    logic arst_n;
    logic flush;
    imm_extend_pipe_if #(.DPW(DPW), .TAG_W(TAG_W)) bus ();

    imm_extend_pipe #(.DPW(DPW), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .flush  (flush),
        .pipe   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];
    logic rdy_ok;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] src);
        logic [31:0] sx;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (src)
            3'd0:    return (sx << 12) | (i >> 20);
            3'd1:    return (sx << 12) | (((i >> 25) & 32'h7F) << 5) | ((i >> 7) & 32'h1F);
            3'd2:    return (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                            | (((i >> 8) & 32'hF) << 1);
            3'd3:    return i & 32'hFFFF_F000;
            3'd4:    return (sx << 20) | (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11)
                            | (((i >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    // Called just after a negedge: drives inputs, checks outputs against the model, advances one edge.
    task automatic step(input logic iv, input logic [31:0] instr, input logic [2:0] src,
                        input logic [4:0] tag, input logic ordy, input logic fl,
                        output logic acc, output logic dlv, output logic [4:0] dtag);
        ent_t e;
        bus.in_valid  = iv;
        bus.instr_ext = instr[31:7];
        bus.immsrc    = src;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check("in_ready", 64'(bus.in_ready), 64'(rdy_ok && q.size() < 2));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("immextD", 64'(bus.immextD), 64'(q[0].imm));
            check("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
`ifdef IMM_EXT_ILLEGAL_CHK_EN
            check("imm_err", 64'(bus.imm_err), 64'(q[0].err));
`endif
        end
        acc  = iv && bus.in_ready;
        dlv  = bus.out_valid && ordy;
        dtag = bus.out_tag;
        @(posedge clk);
        if (fl) begin
            q.delete();
            dlv = 1'b0;
            acc = 1'b0;
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) begin
                e.imm = ref_imm(instr, src);
                e.tag = tag;
                e.err = (src > 3'd4);
                q.push_back(e);
            end
        end
        rdy_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a, d;
        logic [4:0] t;
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, a, d, t);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_imm"}, 64'(bus.immextD), 64'd0);
        check({tag, "_tag"}, 64'(bus.out_tag), 64'd0);
`ifdef IMM_EXT_ILLEGAL_CHK_EN
        check({tag, "_err"}, 64'(bus.imm_err), 64'd0);
`endif
    endtask

    task automatic directed(input string tag, input logic [31:0] instr, input logic [2:0] src,
                            input logic [31:0] exp, input logic exp_err);
        logic a, d;
        logic [4:0] t;
        step(1'b1, instr, src, 5'd9, 1'b1, 1'b0, a, d, t);
        #1;
        check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_imm"}, 64'(bus.immextD), 64'(exp));
`ifdef IMM_EXT_ILLEGAL_CHK_EN
        check({tag, "_err"}, 64'(bus.imm_err), 64'(exp_err));
`else
        if (exp_err) check({tag, "_noerr_imm"}, 64'(bus.immextD), 64'd0);
`endif
        idle(1);
    endtask

    initial begin
        logic a, d;
        logic [4:0] t;
        logic [4:0] seen[$];
        logic       got3;

        arst_n        = 1'b0;
        flush         = 1'b0;
        rdy_ok        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr_ext = '0;
        bus.immsrc    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        arst_n = 1'b1;
        idle(2);

        directed("dir_I", 32'hFFF00093, 3'b000, 32'hFFFF_FFFF, 1'b0);
        directed("dir_S", 32'hFE112E23, 3'b001, 32'hFFFF_FFFC, 1'b0);
        directed("dir_U", 32'h123450B7, 3'b011, 32'h1234_5000, 1'b0);
        directed("dir_J", 32'hFFDFF06F, 3'b100, 32'hFFFF_FFFC, 1'b0);
        directed("dir_ill", 32'hFFFFFFFF, 3'b110, 32'h0, 1'b1);

        // Back-pressure: tags 1,2 fill the pipe, tag 3 must wait.
        step(1'b1, 32'h00100093, 3'd0, 5'd1, 1'b0, 1'b0, a, d, t);
        check("bp_acc1", 64'(a), 64'd1);
        step(1'b1, 32'h00200093, 3'd0, 5'd2, 1'b0, 1'b0, a, d, t);
        check("bp_acc2", 64'(a), 64'd1);
        step(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b0, 1'b0, a, d, t);
        check("bp_acc3_blocked", 64'(a), 64'd0);
        step(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b0, 1'b0, a, d, t);
        check("bp_acc3_still", 64'(a), 64'd0);
        got3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(!got3, 32'h00300093, 3'd0, 5'd3, 1'b1, 1'b0, a, d, t);
            if (a) got3 = 1'b1;
            if (d) seen.push_back(t);
        end
        check("bp_acc3", 64'(got3), 64'd1);
        check("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            check("bp_ord0", 64'(seen[0]), 64'd1);
            check("bp_ord1", 64'(seen[1]), 64'd2);
            check("bp_ord2", 64'(seen[2]), 64'd3);
        end

        // Flush from FULL with a simultaneous input.
        step(1'b1, 32'h00500093, 3'd0, 5'd5, 1'b0, 1'b0, a, d, t);
        step(1'b1, 32'h00600093, 3'd0, 5'd6, 1'b0, 1'b0, a, d, t);
        step(1'b1, 32'h00700093, 3'd0, 5'd7, 1'b1, 1'b1, a, d, t);
        #1;
        check("fl_vld", 64'(bus.out_valid), 64'd0);
        check("fl_rdy", 64'(bus.in_ready), 64'd1);
        seen.delete();
        step(1'b1, 32'h00800093, 3'd0, 5'd8, 1'b1, 1'b0, a, d, t);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, a, d, t);
            if (d) seen.push_back(t);
        end
        check("fl_after_cnt", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) check("fl_after_tag", 64'(seen[0]), 64'd8);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, a, d, t);
        end

        // Asynchronous reset mid-stream, with the pipe holding data.
        step(1'b1, 32'h00A00093, 3'd0, 5'd10, 1'b0, 1'b0, a, d, t);
        step(1'b1, 32'h00B00093, 3'd0, 5'd11, 1'b0, 1'b0, a, d, t);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        q.delete();
        rdy_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        step(1'b1, 32'h00C00093, 3'd0, 5'd12, 1'b1, 1'b0, a, d, t);
        check("arst_first_blocked", 64'(a), 64'd0);
        seen.delete();
        for (int k = 0; k < 5; k++) begin
            step(k < 2, 32'h00D00093 + 32'(k), 3'd0, 5'(13 + k), 1'b1, 1'b0, a, d, t);
            if (d) seen.push_back(t);
        end
        check("arst_cnt", 64'(seen.size()), 64'd2);
        if (seen.size() > 0) check("arst_first_out", 64'(seen[0]), 64'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
